// File: rtl/aes256_pkg.sv
// Shared AES-256 constants, FSM state type and byte/word transforms used by the
// iterative engine and its key-step unit.
package aes256_pkg;

  localparam int AES_NK = 8;
  localparam int AES_NB = 4;
  localparam int AES_NR = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_t;

  localparam logic [7:0] RCON [1:7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  // Entry 0 sits at the most significant end of the literal.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] rcon(input logic [2:0] idx);
    return (idx == 3'd0) ? 8'h00 : RCON[idx];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Byte b of the state lives at [127-8b -: 8]; byte 4c+r is row r of column c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_word(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_col(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_word(s[127-32*c -: 32]);
    return o;
  endfunction

endpackage

// File: rtl/aes256_iter_ctrl_if.sv
// Block-level bus of the iterative AES-256 engine: input and output streams.
// A transfer happens on any rising edge where valid && ready; valid never waits
// on ready, and the source holds data stable while valid is high and ready low.
interface aes256_iter_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plain_text;
  logic [255:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] cipher_text;

  modport master (
    output in_valid, plain_text, key, out_ready,
    input  in_ready, out_valid, cipher_text
  );

  modport slave (
    input  in_valid, plain_text, key, out_ready,
    output in_ready, out_valid, cipher_text
  );
endinterface

// File: rtl/aes256_key_step.sv
// On-the-fly AES-256 key expansion: given the 8-word window w[4r-4..4r+3]
// at round r, produce the next four words w[4r+4..4r+7].
module aes256_key_step
  import aes256_pkg::*;
(
  input  logic [255:0] kwin,
  input  logic [3:0]   round,
  output logic [127:0] next4
);

  logic [2:0]  rc_idx;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    // Odd rounds start a new 8-word group (i = 4r+4 is a multiple of 8).
    rc_idx = 3'((5'({1'b0, round}) + 5'd1) >> 1);
    if (round[0]) temp = sub_word(rot_word(kwin[31:0])) ^ {rcon(rc_idx), 24'h0};
    else          temp = sub_word(kwin[31:0]);
    n0    = kwin[255:224] ^ temp;
    n1    = kwin[223:192] ^ n0;
    n2    = kwin[191:160] ^ n1;
    n3    = kwin[159:128] ^ n2;
    next4 = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes256_iter_ctrl.sv
// Iterative AES-256 encryptor: one round per cycle over 14 cycles, with the key
// schedule expanded on the fly. Optional macro AES256_BACKTOBACK_EN lets a new
// block be accepted on the same edge the previous result is retired.
module aes256_iter_ctrl
  import aes256_pkg::*;
#(
  parameter int NK = AES_NK,
  parameter int NB = AES_NB,
  parameter int NR = AES_NR
) (
  input  logic                clk,
  input  logic                rst,
  aes256_iter_ctrl_if.slave   bus,
  output logic                busy,
  output logic [3:0]          round_idx,
  output aes_state_t          dbg_state
);

  localparam int         ST_W       = 32 * NB;
  localparam int         KEY_W      = 32 * NK;
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  if (NK != 8 || NB != 4 || NR != 14) begin : g_param_check
    $error("aes256_iter_ctrl supports only NK=8, NB=4, NR=14");
  end

  aes_state_t        state_q, state_d;
  logic [ST_W-1:0]   st_q, st_d;
  logic [KEY_W-1:0]  kwin_q, kwin_d;
  logic [3:0]        round_q, round_d;
  logic              load;
  logic [127:0]      next4;
  logic [ST_W-1:0]   sr_s, mc_s, round_out;

  aes256_key_step u_key_step (
    .kwin  (kwin_q),
    .round (round_q),
    .next4 (next4)
  );

  // The final round skips mix_col; the round key is the low half of the window.
  always_comb begin
    sr_s      = shift_rows(sub_bytes(st_q));
    mc_s      = mix_col(sr_s);
    round_out = ((round_q == LAST_ROUND) ? sr_s : mc_s) ^ kwin_q[127:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      kwin_q  <= '0;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      kwin_q  <= kwin_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    kwin_d  = kwin_q;
    round_d = round_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: load = bus.in_valid;
      RUN: begin
        st_d   = round_out;
        kwin_d = {kwin_q[127:0], next4};
        if (round_q == LAST_ROUND) state_d = DONE;
        else                       round_d = round_q + 4'd1;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          round_d = 4'd0;
`ifdef AES256_BACKTOBACK_EN
          load    = bus.in_valid;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        round_d = 4'd0;
      end
    endcase
    // Round 0 (initial AddRoundKey with w0..w3) is folded into the load.
    if (load) begin
      state_d = RUN;
      st_d    = bus.plain_text ^ bus.key[255:128];
      kwin_d  = bus.key;
      round_d = 4'd1;
    end
  end

  always_comb begin
    bus.in_ready    = 1'b0;
    bus.out_valid   = 1'b0;
    bus.cipher_text = '0;
    busy            = 1'b0;
    unique case (state_q)
      IDLE: bus.in_ready = 1'b1;
      RUN:  busy = 1'b1;
      DONE: begin
        bus.out_valid   = 1'b1;
        bus.cipher_text = st_q;
`ifdef AES256_BACKTOBACK_EN
        bus.in_ready    = bus.out_ready;
`endif
      end
      default: ;
    endcase
  end

  assign round_idx = round_q;
  assign dbg_state = state_q;

endmodule
